// File: rtl/dcache_port_if.sv
// Data-cache port bundle shared by the port arbiter and its environment.
//
// Groups the load-queue request, the store-queue request, the cache
// request/response channel and the completion outputs of the arbiter.
//   master : arbiter view (drives grants, cache request, completions, busy)
//   slave  : environment view (drives queue requests and cache responses)
interface dcache_port_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 6
);
    // Load-queue head
    logic                  ld_req_valid;
    logic [ADDR_WIDTH-1:0] ld_req_addr;
    logic [ID_WIDTH-1:0]   ld_req_id;
    logic                  ld_grant;
    // Store-queue commit head
    logic                  st_req_valid;
    logic [ADDR_WIDTH-1:0] st_req_addr;
    logic [DATA_WIDTH-1:0] st_req_data;
    logic                  st_grant;
    // Cache request / response
    logic                  dc_req_valid;
    logic                  dc_req_write;
    logic [ADDR_WIDTH-1:0] dc_req_addr;
    logic [DATA_WIDTH-1:0] dc_req_data;
    logic                  dc_ready;
    logic                  dc_resp_valid;
    logic [DATA_WIDTH-1:0] dc_resp_data;
    // Completions and status
    logic                  ld_done;
    logic [DATA_WIDTH-1:0] ld_done_data;
    logic [ID_WIDTH-1:0]   ld_done_id;
    logic                  st_done;
    logic                  busy;

    modport master (
        input  ld_req_valid, ld_req_addr, ld_req_id,
        input  st_req_valid, st_req_addr, st_req_data,
        input  dc_ready, dc_resp_valid, dc_resp_data,
        output ld_grant, st_grant,
        output dc_req_valid, dc_req_write, dc_req_addr, dc_req_data,
        output ld_done, ld_done_data, ld_done_id, st_done, busy
    );

    modport slave (
        output ld_req_valid, ld_req_addr, ld_req_id,
        output st_req_valid, st_req_addr, st_req_data,
        output dc_ready, dc_resp_valid, dc_resp_data,
        input  ld_grant, st_grant,
        input  dc_req_valid, dc_req_write, dc_req_addr, dc_req_data,
        input  ld_done, ld_done_data, ld_done_id, st_done, busy
    );
endinterface

// File: rtl/dcache_port_arbiter.sv
// Data-cache port arbiter.
//
// Shares a single cache port between the load-queue head (speculative loads)
// and the store-queue commit head (retired stores), with one access
// outstanding at a time. Loads are preferred unless a store has been passed
// over STARVE_LIMIT times in a row. Loads in flight during a branch
// misprediction are dropped silently; committed stores always complete.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   branch_miss  : single-cycle misprediction flush
//   port         : dcache_port_if.master (queue requests/grants, cache
//                  request/response, ld_done/st_done completions, busy)
module dcache_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int ID_WIDTH     = 6,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          branch_miss,
    dcache_port_if.master port
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t                state_r;
    state_t                state_n;
    logic [3:0]            starve_cnt_r;
    logic [3:0]            starve_cnt_n;
    logic                  squash_r;
    logic                  squash_n;

    logic                  ld_elig_s;
    logic                  st_elig_s;
    logic                  ld_grant_s;
    logic                  st_grant_s;
    logic                  resp_ld_s;
    logic                  resp_st_s;

    logic                  op_write_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic [ID_WIDTH-1:0]   id_r;
    logic                  dc_req_valid_r;
    logic                  busy_r;
    logic                  ld_done_r;
    logic [DATA_WIDTH-1:0] ld_done_data_r;
    logic [ID_WIDTH-1:0]   ld_done_id_r;
    logic                  st_done_r;

    // A load on a mispredicted path must not start, even at the flush cycle.
    assign ld_elig_s = port.ld_req_valid && !branch_miss;
    assign st_elig_s = port.st_req_valid;

    // Arbitration: only in IDLE, at most one grant, store wins once starved.
    always_comb begin
        ld_grant_s = 1'b0;
        st_grant_s = 1'b0;
        if (state_r == IDLE) begin
            if (ld_elig_s && st_elig_s) begin
                if (starve_cnt_r >= STARVE_MAX) begin
                    st_grant_s = 1'b1;
                end else begin
                    ld_grant_s = 1'b1;
                end
            end else if (ld_elig_s) begin
                ld_grant_s = 1'b1;
            end else if (st_elig_s) begin
                st_grant_s = 1'b1;
            end else begin
                ld_grant_s = 1'b0;
                st_grant_s = 1'b0;
            end
        end else begin
            ld_grant_s = 1'b0;
            st_grant_s = 1'b0;
        end
    end

    // Store aging: counts loads that jumped ahead of a waiting store.
    always_comb begin
        starve_cnt_n = starve_cnt_r;
        if (st_grant_s) begin
            starve_cnt_n = 4'd0;
        end else if (ld_grant_s && port.st_req_valid && (starve_cnt_r < STARVE_MAX)) begin
            starve_cnt_n = starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_n = starve_cnt_r;
        end
    end

    // Next-state, squash tracking and completion decode.
    always_comb begin
        state_n   = state_r;
        squash_n  = squash_r;
        resp_ld_s = 1'b0;
        resp_st_s = 1'b0;
        case (state_r)
            IDLE: begin
                squash_n = 1'b0;
                if (ld_grant_s || st_grant_s) begin
                    state_n = REQ;
                end else begin
                    state_n = IDLE;
                end
            end
            REQ: begin
                if (port.dc_ready) begin
                    state_n = WAIT;
                    // Accepted in the flush cycle: let it finish, drop result.
                    if (!op_write_r && branch_miss) begin
                        squash_n = 1'b1;
                    end else begin
                        squash_n = squash_r;
                    end
                end else if (!op_write_r && branch_miss) begin
                    // Not yet accepted: withdraw the load outright.
                    state_n = IDLE;
                end else begin
                    state_n = REQ;
                end
            end
            WAIT: begin
                if (port.dc_resp_valid) begin
                    state_n  = IDLE;
                    squash_n = 1'b0;
                    if (op_write_r) begin
                        resp_st_s = 1'b1;
                    end else if (!squash_r && !branch_miss) begin
                        resp_ld_s = 1'b1;
                    end else begin
                        resp_ld_s = 1'b0;
                    end
                end else if (!op_write_r && branch_miss) begin
                    squash_n = 1'b1;
                end else begin
                    squash_n = squash_r;
                end
            end
            default: begin
                state_n  = IDLE;
                squash_n = 1'b0;
            end
        endcase
    end

    // State, aging counter and squash flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            starve_cnt_r <= 4'd0;
            squash_r     <= 1'b0;
        end else begin
            state_r      <= state_n;
            starve_cnt_r <= starve_cnt_n;
            squash_r     <= squash_n;
        end
    end

    // Request capture on grant; fields stay stable until the next grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_write_r <= 1'b0;
            addr_r     <= '0;
            data_r     <= '0;
            id_r       <= '0;
        end else if (st_grant_s) begin
            op_write_r <= 1'b1;
            addr_r     <= port.st_req_addr;
            data_r     <= port.st_req_data;
            id_r       <= '0;
        end else if (ld_grant_s) begin
            op_write_r <= 1'b0;
            addr_r     <= port.ld_req_addr;
            data_r     <= '0;
            id_r       <= port.ld_req_id;
        end
    end

    // Registered status and completion outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dc_req_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            ld_done_r      <= 1'b0;
            ld_done_data_r <= '0;
            ld_done_id_r   <= '0;
            st_done_r      <= 1'b0;
        end else begin
            dc_req_valid_r <= (state_n == REQ);
            busy_r         <= (state_n != IDLE);
            ld_done_r      <= resp_ld_s;
            st_done_r      <= resp_st_s;
            if (resp_ld_s) begin
                ld_done_data_r <= port.dc_resp_data;
                ld_done_id_r   <= id_r;
            end
        end
    end

    assign port.ld_grant     = ld_grant_s;
    assign port.st_grant     = st_grant_s;
    assign port.dc_req_valid = dc_req_valid_r;
    assign port.dc_req_write = op_write_r;
    assign port.dc_req_addr  = addr_r;
    assign port.dc_req_data  = data_r;
    assign port.ld_done      = ld_done_r;
    assign port.ld_done_data = ld_done_data_r;
    assign port.ld_done_id   = ld_done_id_r;
    assign port.st_done      = st_done_r;
    assign port.busy         = busy_r;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed self-checking bench for dcache_port_arbiter.
// Inputs change 1ns after the rising edge; outputs are sampled 2ns after it.
module tb_dcache_port_arbiter;

    logic clk;
    logic rst_n;
    logic branch_miss;
    int   checks;
    int   failures;

    dcache_port_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(6)) bus ();

    dcache_port_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(6), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .branch_miss(branch_miss),
        .port(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1ns past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        #1;
        checks++;
        if (bus.dc_req_valid !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_req_busy: got valid=%b busy=%b, want 0/0", bus.dc_req_valid, bus.busy);
        end
        checks++;
        if (bus.ld_done !== 1'b0 || bus.st_done !== 1'b0 || bus.ld_grant !== 1'b0 || bus.st_grant !== 1'b0) begin
            failures++;
            $display("FAIL reset_done_grant: got ld_done=%b st_done=%b ldg=%b stg=%b, want 0", bus.ld_done, bus.st_done, bus.ld_grant, bus.st_grant);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_load();
        // T
        bus.ld_req_valid = 1'b1;
        bus.ld_req_addr  = 32'h0000_0100;
        bus.ld_req_id    = 6'd5;
        #1;
        checks++;
        if (bus.ld_grant !== 1'b1 || bus.st_grant !== 1'b0) begin
            failures++;
            $display("FAIL single_grant: got ldg=%b stg=%b, want 1/0", bus.ld_grant, bus.st_grant);
        end
        // T+1
        tick();
        bus.ld_req_valid = 1'b0;
        bus.dc_ready     = 1'b1;
        #1;
        checks++;
        if (bus.dc_req_valid !== 1'b1 || bus.dc_req_write !== 1'b0 || bus.dc_req_addr !== 32'h0000_0100 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL single_req: got v=%b w=%b addr=%h busy=%b, want 1/0/100/1", bus.dc_req_valid, bus.dc_req_write, bus.dc_req_addr, bus.busy);
        end
        // T+2
        tick();
        bus.dc_ready      = 1'b0;
        bus.dc_resp_valid = 1'b1;
        bus.dc_resp_data  = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (bus.dc_req_valid !== 1'b0 || bus.busy !== 1'b1 || bus.ld_done !== 1'b0) begin
            failures++;
            $display("FAIL single_wait: got v=%b busy=%b ld_done=%b, want 0/1/0", bus.dc_req_valid, bus.busy, bus.ld_done);
        end
        // T+3
        tick();
        bus.dc_resp_valid = 1'b0;
        #1;
        checks++;
        if (bus.ld_done !== 1'b1 || bus.ld_done_data !== 32'hDEAD_BEEF || bus.ld_done_id !== 6'd5 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL single_done: got done=%b data=%h id=%0d busy=%b, want 1/deadbeef/5/0", bus.ld_done, bus.ld_done_data, bus.ld_done_id, bus.busy);
        end
        // T+4
        tick();
        #1;
        checks++;
        if (bus.ld_done !== 1'b0) begin
            failures++;
            $display("FAIL single_done_pulse: got ld_done=%b, want 0", bus.ld_done);
        end
    endtask

    task automatic test_contention();
        logic [9:0] exp_st;
        exp_st = 10'b10_0001_0000;   // grant order L,L,L,L,S,L,L,L,L,S
        bus.ld_req_valid = 1'b1;
        bus.ld_req_addr  = 32'h0000_0180;
        bus.ld_req_id    = 6'd7;
        bus.st_req_valid = 1'b1;
        bus.st_req_addr  = 32'h0000_0200;
        bus.st_req_data  = 32'h0BAD_F00D;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (bus.st_grant !== exp_st[i] || bus.ld_grant !== !exp_st[i]) begin
                failures++;
                $display("FAIL contention_grant[%0d]: got ldg=%b stg=%b, want stg=%b", i, bus.ld_grant, bus.st_grant, exp_st[i]);
            end
            if (i > 0) begin
                checks++;
                if (bus.st_done !== exp_st[i-1] || bus.ld_done !== !exp_st[i-1]) begin
                    failures++;
                    $display("FAIL contention_done[%0d]: got ld_done=%b st_done=%b, want st_done=%b", i - 1, bus.ld_done, bus.st_done, exp_st[i-1]);
                end
            end
            tick();
            bus.dc_ready = 1'b1;
            if (exp_st[i]) begin
                checks++;
                if (dut.starve_cnt_r !== 4'd0) begin
                    failures++;
                    $display("FAIL contention_starve_clr[%0d]: got %0d, want 0", i, dut.starve_cnt_r);
                end
            end
            tick();
            bus.dc_ready      = 1'b0;
            bus.dc_resp_valid = 1'b1;
            bus.dc_resp_data  = 32'h1111_0000 + 32'(i);
            if (i == 9) begin
                bus.ld_req_valid = 1'b0;
                bus.st_req_valid = 1'b0;
            end
            tick();
            bus.dc_resp_valid = 1'b0;
        end
        #1;
        checks++;
        if (bus.st_done !== 1'b1 || bus.ld_grant !== 1'b0 || bus.st_grant !== 1'b0) begin
            failures++;
            $display("FAIL contention_last: got st_done=%b ldg=%b stg=%b, want 1/0/0", bus.st_done, bus.ld_grant, bus.st_grant);
        end
        tick();
    endtask

    task automatic test_squash_wait();
        bus.st_req_valid = 1'b1;
        bus.st_req_addr  = 32'h0000_0300;
        bus.st_req_data  = 32'hCAFE_0001;
        bus.ld_req_valid = 1'b1;
        bus.ld_req_addr  = 32'h0000_0340;
        bus.ld_req_id    = 6'd9;
        #1;
        checks++;
        if (bus.ld_grant !== 1'b1 || bus.st_grant !== 1'b0) begin
            failures++;
            $display("FAIL sqw_grant: got ldg=%b stg=%b, want 1/0", bus.ld_grant, bus.st_grant);
        end
        tick();                         // REQ
        bus.ld_req_valid = 1'b0;
        bus.dc_ready     = 1'b1;
        tick();                         // WAIT
        bus.dc_ready     = 1'b0;
        branch_miss      = 1'b1;
        tick();                         // WAIT, squashed
        branch_miss       = 1'b0;
        bus.dc_resp_valid = 1'b1;
        bus.dc_resp_data  = 32'hAAAA_5555;
        #1;
        checks++;
        if (bus.busy !== 1'b1 || bus.st_grant !== 1'b0) begin
            failures++;
            $display("FAIL sqw_wait: got busy=%b stg=%b, want 1/0", bus.busy, bus.st_grant);
        end
        tick();                         // IDLE
        bus.dc_resp_valid = 1'b0;
        #1;
        checks++;
        if (bus.ld_done !== 1'b0 || bus.busy !== 1'b0 || bus.st_grant !== 1'b1) begin
            failures++;
            $display("FAIL sqw_idle: got ld_done=%b busy=%b stg=%b, want 0/0/1", bus.ld_done, bus.busy, bus.st_grant);
        end
        tick();                         // REQ (store)
        bus.st_req_valid = 1'b0;
        bus.dc_ready     = 1'b1;
        #1;
        checks++;
        if (bus.dc_req_write !== 1'b1 || bus.dc_req_addr !== 32'h0000_0300) begin
            failures++;
            $display("FAIL sqw_store_req: got w=%b addr=%h, want 1/300", bus.dc_req_write, bus.dc_req_addr);
        end
        tick();                         // WAIT
        bus.dc_ready      = 1'b0;
        bus.dc_resp_valid = 1'b1;
        tick();
        bus.dc_resp_valid = 1'b0;
        #1;
        checks++;
        if (bus.st_done !== 1'b1 || bus.ld_done !== 1'b0) begin
            failures++;
            $display("FAIL sqw_st_done: got st_done=%b ld_done=%b, want 1/0", bus.st_done, bus.ld_done);
        end
        tick();
    endtask

    task automatic test_squash_req();
        // Flush before acceptance: request withdrawn.
        bus.ld_req_valid = 1'b1;
        bus.ld_req_addr  = 32'h0000_0400;
        bus.ld_req_id    = 6'd12;
        tick();                         // REQ
        bus.ld_req_valid = 1'b0;
        branch_miss      = 1'b1;
        bus.dc_ready     = 1'b0;
        tick();
        branch_miss      = 1'b0;
        #1;
        checks++;
        if (bus.dc_req_valid !== 1'b0 || bus.busy !== 1'b0 || bus.ld_done !== 1'b0) begin
            failures++;
            $display("FAIL sqr_withdraw: got v=%b busy=%b ld_done=%b, want 0/0/0", bus.dc_req_valid, bus.busy, bus.ld_done);
        end
        tick();
        // Flush in the accept cycle: access completes, result dropped.
        bus.ld_req_valid = 1'b1;
        bus.ld_req_id    = 6'd13;
        tick();                         // REQ
        bus.ld_req_valid = 1'b0;
        branch_miss      = 1'b1;
        bus.dc_ready     = 1'b1;
        tick();                         // WAIT
        branch_miss       = 1'b0;
        bus.dc_ready      = 1'b0;
        bus.dc_resp_valid = 1'b1;
        bus.dc_resp_data  = 32'h7777_8888;
        #1;
        checks++;
        if (bus.busy !== 1'b1 || bus.dc_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL sqr_accept_wait: got busy=%b v=%b, want 1/0", bus.busy, bus.dc_req_valid);
        end
        tick();
        bus.dc_resp_valid = 1'b0;
        #1;
        checks++;
        if (bus.ld_done !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL sqr_accept_done: got ld_done=%b busy=%b, want 0/0", bus.ld_done, bus.busy);
        end
        tick();
    endtask

    task automatic test_store_branch_miss();
        bus.st_req_valid = 1'b1;
        bus.st_req_addr  = 32'h0000_0040;
        bus.st_req_data  = 32'h1234_5678;
        #1;
        checks++;
        if (bus.st_grant !== 1'b1) begin
            failures++;
            $display("FAIL stbm_grant: got stg=%b, want 1", bus.st_grant);
        end
        tick();                         // REQ
        bus.st_req_valid = 1'b0;
        bus.dc_ready     = 1'b1;
        #1;
        checks++;
        if (bus.dc_req_valid !== 1'b1 || bus.dc_req_write !== 1'b1 || bus.dc_req_addr !== 32'h0000_0040 || bus.dc_req_data !== 32'h1234_5678) begin
            failures++;
            $display("FAIL stbm_req: got v=%b w=%b addr=%h data=%h, want 1/1/40/12345678", bus.dc_req_valid, bus.dc_req_write, bus.dc_req_addr, bus.dc_req_data);
        end
        tick();                         // WAIT
        bus.dc_ready = 1'b0;
        branch_miss  = 1'b1;
        tick();
        branch_miss       = 1'b0;
        bus.dc_resp_valid = 1'b1;
        tick();
        bus.dc_resp_valid = 1'b0;
        #1;
        checks++;
        if (bus.st_done !== 1'b1) begin
            failures++;
            $display("FAIL stbm_done: got st_done=%b, want 1", bus.st_done);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        bus.ld_req_valid = 1'b1;
        bus.ld_req_addr  = 32'h0000_0500;
        bus.ld_req_id    = 6'd21;
        tick();                         // REQ
        bus.ld_req_valid = 1'b0;
        bus.dc_ready     = 1'b1;
        tick();                         // WAIT
        bus.dc_ready = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre: got busy=%b, want 1", bus.busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.dc_req_valid !== 1'b0 || bus.busy !== 1'b0 || bus.ld_done !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid: got v=%b busy=%b ld_done=%b, want 0/0/0", bus.dc_req_valid, bus.busy, bus.ld_done);
        end
        tick();
        rst_n = 1'b1;
        tick();
        bus.dc_resp_valid = 1'b1;
        bus.dc_resp_data  = 32'hBADB_AD00;
        tick();
        bus.dc_resp_valid = 1'b0;
        #1;
        checks++;
        if (bus.ld_done !== 1'b0 || bus.st_done !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_stray: got ld_done=%b st_done=%b busy=%b, want 0/0/0", bus.ld_done, bus.st_done, bus.busy);
        end
        tick();
        #1;
        checks++;
        if (bus.ld_done !== 1'b0 || bus.st_done !== 1'b0) begin
            failures++;
            $display("FAIL rst_stray_late: got ld_done=%b st_done=%b, want 0/0", bus.ld_done, bus.st_done);
        end
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        rst_n             = 1'b0;
        branch_miss       = 1'b0;
        bus.ld_req_valid  = 1'b0;
        bus.ld_req_addr   = 32'h0;
        bus.ld_req_id     = 6'd0;
        bus.st_req_valid  = 1'b0;
        bus.st_req_addr   = 32'h0;
        bus.st_req_data   = 32'h0;
        bus.dc_ready      = 1'b0;
        bus.dc_resp_valid = 1'b0;
        bus.dc_resp_data  = 32'h0;

        test_reset();
        test_single_load();
        test_contention();
        test_squash_wait();
        test_squash_req();
        test_store_branch_miss();
        test_reset_mid_wait();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
